// File: rtl/sim_ctrl.sv
// sim_ctrl: simulation run controller with a result register, cycle counter,
// watchdog timeout and a small console byte FIFO on a 4-word register bus.
module sim_ctrl #(
  parameter int WATCHDOG  = 10000,
  parameter int CON_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        halt,
  output logic        pass,
  output logic        fail
);

  localparam int PW = $clog2(CON_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] WD_LAST = 32'(WATCHDOG - 1);

  typedef enum logic {
    RUN,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] cycle;
  logic [31:0] result;
  logic        timeout;

  logic [7:0]    mem [CON_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic        res_wr;
  logic        con_wr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;
  logic [31:0] rd_mux;

  assign res_wr   = req && we && (addr == 2'd0);
  assign con_wr   = req && we && (addr == 2'd2);
  assign empty    = (count == '0);
  assign full     = (count == CW'(CON_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid && tx_ready;
  // A full FIFO still takes a byte when the head leaves the same cycle.
  assign push     = con_wr && (!full || pop);

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      2'd0: rd_mux = result;
      2'd1: rd_mux = cycle;
      2'd2: rd_mux = 32'({count, overflow, full, empty});
      2'd3: rd_mux = {28'd0, timeout, fail, pass, halt};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= req;
      rdata <= req ? rd_mux : '0;
    end
  end

  // The ending edge does not advance CYCLE, so it reads the final cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      cycle   <= '0;
      result  <= '0;
      halt    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else if (state == RUN) begin
      if (res_wr) begin
        state  <= DONE;
        result <= wdata;
        halt   <= 1'b1;
        pass   <= (wdata == 32'h55);
        fail   <= (wdata != 32'h55);
      end else if (cycle == WD_LAST) begin
        state   <= DONE;
        halt    <= 1'b1;
        fail    <= 1'b1;
        timeout <= 1'b1;
      end else begin
        cycle <= cycle + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (con_wr && !push)
        overflow <= 1'b1;
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr] <= wdata[7:0];
  end

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: directed scenarios plus a randomized
// console FIFO run against a queue-based reference model.
module tb_sim_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_b = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic        tx_ready = 1'b0;

  logic [31:0] rdata;
  logic        ack;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        halt;
  logic        pass;
  logic        fail;

  logic [31:0] rdata_b;
  logic        ack_b;
  logic        tx_valid_b;
  logic [7:0]  tx_data_b;
  logic        halt_b;
  logic        pass_b;
  logic        fail_b;

  int checks = 0;
  int failures = 0;

  logic        ak;
  logic [31:0] rd;

  always #5 clk = ~clk;

  sim_ctrl #(.WATCHDOG(1000), .CON_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .halt(halt),
    .pass(pass), .fail(fail)
  );

  sim_ctrl #(.WATCHDOG(16), .CON_DEPTH(DEPTH)) dut_wd (
    .clk(clk), .reset(reset_b), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata_b), .ack(ack_b), .tx_valid(tx_valid_b),
    .tx_ready(1'b0), .tx_data(tx_data_b), .halt(halt_b),
    .pass(pass_b), .fail(fail_b)
  );

  task automatic bus(input logic w, input logic [1:0] a,
                     input logic [31:0] d,
                     output logic k, output logic [31:0] r);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    we = 1'b0;
    k = ack;
    r = rdata;
  endtask

  task automatic do_reset();
    req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 1'b1;
    we = 1'b1;
    addr = 2'd0;
    wdata = 32'h55;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({halt, pass, fail, ack, tx_valid} !== 5'b0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_outs got=%b rdata=%h exp=00000 rdata=0",
               {halt, pass, fail, ack, tx_valid}, rdata);
    end
    req = 1'b0;
    we = 1'b0;
    reset = 1'b0;
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_cycle got ack=%b val=%0d exp ack=1 val=0", ak, rd);
    end
    bus(1'b0, 2'd3, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL reset_status got=%h exp=0", rd);
    end
    bus(1'b0, 2'd2, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL reset_console got=%h exp=1", rd);
    end
  endtask

  task automatic test_ignored_writes();
    do_reset();
    bus(1'b1, 2'd1, 32'hdeadbeef, ak, rd);
    checks++;
    if (ak !== 1'b1) begin
      failures++;
      $display("FAIL cycle_wr_ack got=%b exp=1", ak);
    end
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd1) begin
      failures++;
      $display("FAIL cycle_wr_ignored got=%h exp=1", rd);
    end
    bus(1'b1, 2'd3, 32'hf, ak, rd);
    bus(1'b0, 2'd3, 32'd0, ak, rd);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      failures++;
      $display("FAIL status_wr_ignored got ack=%b val=%h exp ack=1 val=0",
               ak, rd);
    end
  endtask

  task automatic test_pass();
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    bus(1'b1, 2'd0, 32'h55, ak, rd);
    checks++;
    if ({halt, pass, fail} !== 3'b110) begin
      failures++;
      $display("FAIL pass_flags got=%b exp=110", {halt, pass, fail});
    end
    repeat (7) @(posedge clk);
    #1;
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd20) begin
      failures++;
      $display("FAIL pass_cycle_frozen got=%0d exp=20", rd);
    end
    bus(1'b0, 2'd3, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'h3) begin
      failures++;
      $display("FAIL pass_status got=%h exp=3", rd);
    end
  endtask

  task automatic test_fail();
    int n;
    n = $urandom_range(1, 60);
    do_reset();
    repeat (n) @(posedge clk);
    #1;
    bus(1'b1, 2'd0, 32'hAA, ak, rd);
    checks++;
    if ({halt, pass, fail} !== 3'b101) begin
      failures++;
      $display("FAIL fail_flags got=%b exp=101", {halt, pass, fail});
    end
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL idle_bus got ack=%b rdata=%h exp ack=0 rdata=0",
               ack, rdata);
    end
    bus(1'b1, 2'd0, 32'h55, ak, rd);
    checks++;
    if (ak !== 1'b1 || pass !== 1'b0) begin
      failures++;
      $display("FAIL done_wr got ack=%b pass=%b exp ack=1 pass=0", ak, pass);
    end
    bus(1'b0, 2'd0, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'hAA) begin
      failures++;
      $display("FAIL result_kept got=%h exp=aa", rd);
    end
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'(n)) begin
      failures++;
      $display("FAIL fail_cycle got=%0d exp=%0d", rd, n);
    end
    bus(1'b0, 2'd3, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'h5) begin
      failures++;
      $display("FAIL fail_status got=%h exp=5", rd);
    end
  endtask

  task automatic test_watchdog();
    reset = 1'b1;
    req = 1'b0;
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (halt_b !== 1'b0) begin
      failures++;
      $display("FAIL wd_early got=%b exp=0", halt_b);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({halt_b, pass_b, fail_b, tx_valid_b} !== 4'b1010) begin
      failures++;
      $display("FAIL wd_flags got=%b exp=1010",
               {halt_b, pass_b, fail_b, tx_valid_b});
    end
    bus(1'b0, 2'd3, 32'd0, ak, rd);
    checks++;
    if (ack_b !== 1'b1 || rdata_b !== 32'hD) begin
      failures++;
      $display("FAIL wd_status got ack=%b val=%h exp ack=1 val=d",
               ack_b, rdata_b);
    end
    bus(1'b0, 2'd0, 32'd0, ak, rd);
    checks++;
    if (rdata_b !== 32'd0) begin
      failures++;
      $display("FAIL wd_result got=%h exp=0", rdata_b);
    end
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    bus(1'b1, 2'd0, 32'h55, ak, rd);
    checks++;
    if ({halt_b, pass_b, fail_b} !== 3'b110) begin
      failures++;
      $display("FAIL wd_race_flags got=%b exp=110", {halt_b, pass_b, fail_b});
    end
    bus(1'b0, 2'd3, 32'd0, ak, rd);
    checks++;
    if (rdata_b !== 32'h3) begin
      failures++;
      $display("FAIL wd_race_status got=%h exp=3", rdata_b);
    end
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (rdata_b !== 32'd15) begin
      failures++;
      $display("FAIL wd_race_cycle got=%0d exp=15", rdata_b);
    end
    reset_b = 1'b1;
  endtask

  task automatic test_console_full();
    logic [7:0] exp_b [5];
    exp_b[0] = 8'h41;
    exp_b[1] = 8'h42;
    exp_b[2] = 8'h43;
    exp_b[3] = 8'h44;
    exp_b[4] = 8'h45;
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      bus(1'b1, 2'd2, {24'd0, exp_b[i]}, ak, rd);
    bus(1'b0, 2'd2, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd38 || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL con_full got=%h valid=%b exp=26 valid=1", rd, tx_valid);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        failures++;
        $display("FAIL con_drain%0d got valid=%b data=%h exp valid=1 data=%h",
                 i, tx_valid, tx_data, exp_b[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL con_drained got=%b exp=0", tx_valid);
    end
    @(posedge clk);
    #1;
    bus(1'b0, 2'd2, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd5) begin
      failures++;
      $display("FAIL con_sticky got=%h exp=5", rd);
    end
  endtask

  task automatic test_console_passthru();
    do_reset();
    tx_ready = 1'b1;
    bus(1'b1, 2'd2, 32'h5A, ak, rd);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
      failures++;
      $display("FAIL con_pass got valid=%b data=%h exp valid=1 data=5a",
               tx_valid, tx_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL con_pass_pop got=%b exp=0", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  q [$];
    logic        ovf;
    logic        prev;
    logic        push;
    logic        was_full;
    logic        popv;
    logic [7:0]  exp_d;
    logic [31:0] exp_s;
    do_reset();
    ovf = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      push = ($urandom_range(0, 9) < 7);
      req = push;
      we = 1'b1;
      addr = 2'd2;
      wdata = $urandom;
      tx_ready = ($urandom_range(0, 9) < 4);
      @(negedge clk);
      exp_d = (q.size() != 0) ? q[0] : 8'd0;
      checks++;
      if (tx_valid !== (q.size() != 0) ||
          (q.size() != 0 && tx_data !== exp_d) || ack !== prev) begin
        failures++;
        $display("FAIL rand_fifo cyc=%0d got v=%b d=%h ack=%b exp v=%b d=%h ack=%b",
                 i, tx_valid, tx_data, ack, (q.size() != 0), exp_d, prev);
      end
      was_full = (q.size() == DEPTH);
      popv = (q.size() != 0) && tx_ready;
      if (popv)
        void'(q.pop_front());
      if (push) begin
        if (!was_full || popv)
          q.push_back(wdata[7:0]);
        else
          ovf = 1'b1;
      end
      prev = push;
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    we = 1'b0;
    tx_ready = 1'b0;
    bus(1'b0, 2'd2, 32'd0, ak, rd);
    exp_s = (32'(q.size()) << 3) | (32'(ovf) << 2) |
            (32'(q.size() == DEPTH) << 1) | 32'(q.size() == 0);
    checks++;
    if (rd !== exp_s) begin
      failures++;
      $display("FAIL rand_status got=%h exp=%h", rd, exp_s);
    end
  endtask

  task automatic test_reset_done();
    do_reset();
    tx_ready = 1'b0;
    bus(1'b1, 2'd0, 32'h1, ak, rd);
    bus(1'b1, 2'd2, 32'h31, ak, rd);
    bus(1'b1, 2'd2, 32'h32, ak, rd);
    checks++;
    if (halt !== 1'b1 || tx_valid !== 1'b1 || ak !== 1'b1) begin
      failures++;
      $display("FAIL done_push got halt=%b valid=%b ack=%b exp 1 1 1",
               halt, tx_valid, ak);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (halt !== 1'b0 || tx_valid !== 1'b0 || ack !== 1'b0) begin
      failures++;
      $display("FAIL done_reset got halt=%b valid=%b ack=%b exp 0 0 0",
               halt, tx_valid, ack);
    end
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd0) begin
      failures++;
      $display("FAIL done_reset_cycle0 got=%0d exp=0", rd);
    end
    bus(1'b0, 2'd1, 32'd0, ak, rd);
    checks++;
    if (rd !== 32'd1 || halt !== 1'b0) begin
      failures++;
      $display("FAIL done_reset_count got=%0d halt=%b exp=1 halt=0", rd, halt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_ignored_writes();
    test_pass();
    test_fail();
    test_watchdog();
    test_console_full();
    test_console_passthru();
    test_random();
    test_reset_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
